matrix_in_loader: RTL and testbench

Upstream feeder for the matrix engine's eight DAC input RAMs (in_ram1..in_ram8, 64 × 256 bit each). Accepts a 32-bit valid/ready stream and packs eight beats per RAM word. Issues channel-major write strobes (ch1 addr 0..63, then ch2, … ch8) in place of the bench-forced in_ramN_wen/wadrs/wdat. Signals completion so control can fire the execution trigger.

---
 rtl/matrix_pkg.sv | 18 +
 rtl/matrix_beat_packer.sv | 52 +++++
 rtl/matrix_in_loader.sv | 112 +++++++++++
 tb/tb_matrix_in_loader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants and loader state encoding for the matrix engine input path.
// State codes stay fixed because they appear on the STATE-style debug bus.
package matrix_pkg;

    localparam int CH_NUM = 8;
    localparam int DEPTH  = 64;
    localparam int AW     = 6;
    localparam int DW     = 256;
    localparam int SW     = 32;

    typedef enum logic [3:0] {
        LDR_IDLE = 4'd0,
        LDR_LOAD = 4'd1,
        LDR_LAST = 4'd2,
        LDR_DONE = 4'd3
    } ldr_state_t;

endpackage

// File: rtl/matrix_beat_packer.sv
// Packs DW/SW stream beats into one RAM word, first beat in the low slice.
// The final beat is forwarded combinationally so the word is complete on its handshake.
module matrix_beat_packer #(
    parameter int DW = 256,
    parameter int SW = 32
) (
    input  logic          clk_250MHz,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_beat_en,
    input  logic [SW-1:0] i_data,
    output logic [DW-1:0] o_word,
    output logic          o_word_valid
);
    import matrix_pkg::*;

    localparam int NB = DW / SW;
    localparam int BW = $clog2(NB);

    logic [BW-1:0] r_beat;
    logic [SW-1:0] r_slot [NB-1];

    always_ff @(posedge clk_250MHz or posedge rst) begin
        if (rst) begin
            r_beat <= '0;
        end else if (i_clr) begin
            r_beat <= '0;
        end else if (i_beat_en) begin
            r_beat <= r_beat + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB - 1; gi++) begin : g_slot
            always_ff @(posedge clk_250MHz or posedge rst) begin
                if (rst) begin
                    r_slot[gi] <= '0;
                end else if (i_clr) begin
                    r_slot[gi] <= '0;
                end else if (i_beat_en && (r_beat == BW'(gi))) begin
                    r_slot[gi] <= i_data;
                end
            end
            assign o_word[gi*SW +: SW] = r_slot[gi];
        end
    endgenerate

    assign o_word[DW-1 -: SW] = i_data;
    assign o_word_valid       = i_beat_en && (r_beat == BW'(NB - 1));

endmodule

// File: rtl/matrix_in_loader.sv
// Streams 32-bit beats into the eight DAC input RAMs, channel-major, then pulses done.
// Write strobe/address/data are registered; abort or reset cancels any pending write.
module matrix_in_loader #(
    parameter int CH_NUM = matrix_pkg::CH_NUM,
    parameter int DEPTH  = matrix_pkg::DEPTH,
    parameter int AW     = matrix_pkg::AW,
    parameter int DW     = matrix_pkg::DW,
    parameter int SW     = matrix_pkg::SW
) (
    input  logic              clk_250MHz,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [SW-1:0]     s_data,
    output logic              s_ready,
    output logic [CH_NUM-1:0] in_ram_wen,
    output logic [AW-1:0]     in_ram_wadrs,
    output logic [DW-1:0]     in_ram_wdat,
    output logic              busy,
    output logic              done
);
    import matrix_pkg::*;

    localparam int CW = $clog2(CH_NUM);

    ldr_state_t        r_state;
    logic [AW-1:0]     r_adr;
    logic [CW-1:0]     r_ch;
    logic [CH_NUM-1:0] r_wen;
    logic [AW-1:0]     r_wadrs;
    logic [DW-1:0]     r_wdat;

    logic              w_hs;
    logic              w_pack_clr;
    logic [DW-1:0]     w_word;
    logic              w_word_valid;
    logic              w_adr_wrap;
    logic              w_last_word;

    assign w_hs        = (r_state == LDR_LOAD) && s_valid;
    assign w_pack_clr  = abort || ((r_state == LDR_IDLE) && start);
    assign w_adr_wrap  = (r_adr == AW'(DEPTH - 1));
    assign w_last_word = w_word_valid && w_adr_wrap && (r_ch == CW'(CH_NUM - 1));

    matrix_beat_packer #(
        .DW (DW),
        .SW (SW)
    ) u_packer (
        .clk_250MHz   (clk_250MHz),
        .rst          (rst),
        .i_clr        (w_pack_clr),
        .i_beat_en    (w_hs),
        .i_data       (s_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

    always_ff @(posedge clk_250MHz or posedge rst) begin
        if (rst) begin
            r_state <= LDR_IDLE;
            r_adr   <= '0;
            r_ch    <= '0;
            r_wen   <= '0;
            r_wadrs <= '0;
            r_wdat  <= '0;
        end else begin
            r_wen <= '0;
            // Abort outranks everything, including a word completing on this edge.
            if (abort) begin
                r_state <= LDR_IDLE;
                r_adr   <= '0;
                r_ch    <= '0;
            end else begin
                case (r_state)
                    LDR_IDLE: begin
                        if (start) begin
                            r_state <= LDR_LOAD;
                            r_adr   <= '0;
                            r_ch    <= '0;
                        end
                    end
                    LDR_LOAD: begin
                        if (w_word_valid) begin
                            r_wen   <= CH_NUM'(1) << r_ch;
                            r_wadrs <= r_adr;
                            r_wdat  <= w_word;
                            r_adr   <= w_adr_wrap ? '0 : r_adr + 1'b1;
                            if (w_adr_wrap) begin
                                r_ch <= r_ch + 1'b1;
                            end
                            if (w_last_word) begin
                                r_state <= LDR_LAST;
                            end
                        end
                    end
                    LDR_LAST: r_state <= LDR_DONE;
                    LDR_DONE: r_state <= LDR_IDLE;
                    default:  r_state <= LDR_IDLE;
                endcase
            end
        end
    end

    assign s_ready      = (r_state == LDR_LOAD);
    assign busy         = (r_state != LDR_IDLE);
    assign done         = (r_state == LDR_DONE);
    assign in_ram_wen   = r_wen;
    assign in_ram_wadrs = r_wadrs;
    assign in_ram_wdat  = r_wdat;

endmodule

// File: tb/tb_matrix_in_loader.sv
// Bench for matrix_in_loader: bench-side packing model feeds a write scoreboard,
// per-scenario tasks check control behaviour inline.
module tb_matrix_in_loader;

    logic         clk_250MHz = 1'b0;
    logic         rst        = 1'b1;
    logic         start      = 1'b0;
    logic         abort      = 1'b0;
    logic         s_valid    = 1'b0;
    logic [31:0]  s_data     = '0;
    logic         s_ready;
    logic [7:0]   in_ram_wen;
    logic [5:0]   in_ram_wadrs;
    logic [255:0] in_ram_wdat;
    logic         busy;
    logic         done;

    matrix_in_loader dut (
        .clk_250MHz   (clk_250MHz),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .in_ram_wen   (in_ram_wen),
        .in_ram_wadrs (in_ram_wadrs),
        .in_ram_wdat  (in_ram_wdat),
        .busy         (busy),
        .done         (done)
    );

    always #2 clk_250MHz = ~clk_250MHz;

    typedef struct {
        logic [7:0]   wen;
        logic [5:0]   adr;
        logic [255:0] dat;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         e;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           wen_cnt, done_cnt, last_wen_cyc, done_cyc, busy_fall_cyc;
    logic         prev_busy = 1'b0;
    int           beat_idx;
    logic [255:0] acc;

    always @(posedge clk_250MHz) cyc <= cyc + 1;

    // Write monitor: every strobe must match the oldest expected write, on its cycle.
    always @(negedge clk_250MHz) begin
        if (!rst) begin
            if (in_ram_wen != 8'h00) begin
                wen_cnt++;
                last_wen_cyc = cyc;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wen got wen=%h adr=%0d cyc=%0d required no write",
                             in_ram_wen, in_ram_wadrs, cyc);
                end else begin
                    e = sb.pop_front();
                    if (in_ram_wen !== e.wen || in_ram_wadrs !== e.adr ||
                        in_ram_wdat !== e.dat || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL write got wen=%h adr=%0d cyc=%0d dat=%h required wen=%h adr=%0d cyc=%0d dat=%h",
                                 in_ram_wen, in_ram_wadrs, cyc, in_ram_wdat, e.wen, e.adr, e.cyc, e.dat);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_busy && !busy) busy_fall_cyc = cyc;
            prev_busy = busy;
        end
    end

    task automatic clear_book();
        sb.delete();
        wen_cnt       = 0;
        done_cnt      = 0;
        last_wen_cyc  = -1;
        done_cyc      = -1;
        busy_fall_cyc = -1;
        beat_idx      = 0;
        acc           = '0;
    endtask

    task automatic pulse_start(input string name);
        @(posedge clk_250MHz); #1 start = 1'b1;
        @(posedge clk_250MHz); #1 start = 1'b0;
        checks += 2;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL %s_busy got %b required 1", name, busy);
        end
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL %s_s_ready got %b required 1", name, s_ready);
        end
    endtask

    // Drives beats carrying their own index until n are accepted; models the packed words.
    task automatic stream(input int n, input bit rnd, input int start_at);
        int guard = 0;
        bit sent  = 1'b0;
        int word;
        while (beat_idx < n && guard < 40000) begin
            @(posedge clk_250MHz); #1;
            guard++;
            start = 1'b0;
            if (start_at >= 0 && beat_idx == start_at && !sent) begin
                start = 1'b1;
                sent  = 1'b1;
            end
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = 32'(beat_idx);
            if (s_valid && s_ready) begin
                acc[(beat_idx % 8) * 32 +: 32] = 32'(beat_idx);
                if (beat_idx % 8 == 7) begin
                    word = beat_idx / 8;
                    sb.push_back('{wen: 8'(8'h01 << (word / 64)), adr: 6'(word % 64),
                                   dat: acc, cyc: cyc + 1});
                end
                beat_idx++;
            end
        end
        @(posedge clk_250MHz); #1;
        s_valid = 1'b0;
        start   = 1'b0;
        checks++;
        if (beat_idx < n) begin
            errors++; $display("FAIL stream_timeout got %0d beats required %0d", beat_idx, n);
        end
    endtask

    task automatic check_complete(input string name);
        repeat (10) @(negedge clk_250MHz);
        checks += 6;
        if (wen_cnt != 512) begin
            errors++; $display("FAIL %s_wen_count got %0d required 512", name, wen_cnt);
        end
        if (done_cnt != 1) begin
            errors++; $display("FAIL %s_done_count got %0d required 1", name, done_cnt);
        end
        if (done_cyc != last_wen_cyc + 1) begin
            errors++; $display("FAIL %s_done_timing got %0d required %0d", name, done_cyc, last_wen_cyc + 1);
        end
        if (busy_fall_cyc != done_cyc + 1) begin
            errors++; $display("FAIL %s_busy_fall got %0d required %0d", name, busy_fall_cyc, done_cyc + 1);
        end
        if (sb.size() != 0) begin
            errors++; $display("FAIL %s_missing_writes got %0d pending required 0", name, sb.size());
        end
        if (busy !== 1'b0) begin
            errors++; $display("FAIL %s_idle_busy got %b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk_250MHz);
        checks += 6;
        if (s_ready !== 1'b0)         begin errors++; $display("FAIL rst_s_ready got %b required 0", s_ready); end
        if (in_ram_wen !== 8'h00)     begin errors++; $display("FAIL rst_wen got %h required 00", in_ram_wen); end
        if (in_ram_wadrs !== 6'd0)    begin errors++; $display("FAIL rst_wadrs got %0d required 0", in_ram_wadrs); end
        if (in_ram_wdat !== 256'd0)   begin errors++; $display("FAIL rst_wdat got %h required 0", in_ram_wdat); end
        if (busy !== 1'b0)            begin errors++; $display("FAIL rst_busy got %b required 0", busy); end
        if (done !== 1'b0)            begin errors++; $display("FAIL rst_done got %b required 0", done); end
        @(posedge clk_250MHz); #1 rst = 1'b0;
    endtask

    task automatic test_full_load();
        clear_book();
        pulse_start("full");
        stream(4096, 1'b0, -1);
        check_complete("full");
    endtask

    task automatic test_random_valid();
        clear_book();
        pulse_start("rand");
        stream(4096, 1'b1, -1);
        check_complete("rand");
    endtask

    task automatic test_start_while_busy();
        clear_book();
        pulse_start("restart");
        stream(4096, 1'b0, 100);
        check_complete("restart");
    endtask

    task automatic test_abort_mid();
        clear_book();
        pulse_start("abort_mid");
        stream(12, 1'b0, -1);
        abort = 1'b1;
        @(posedge clk_250MHz); #1 abort = 1'b0;
        checks += 2;
        if (busy !== 1'b0)    begin errors++; $display("FAIL abort_mid_busy got %b required 0", busy); end
        if (s_ready !== 1'b0) begin errors++; $display("FAIL abort_mid_s_ready got %b required 0", s_ready); end
        repeat (5) @(negedge clk_250MHz);
        checks += 2;
        if (wen_cnt != 1)  begin errors++; $display("FAIL abort_mid_wen_count got %0d required 1", wen_cnt); end
        if (done_cnt != 0) begin errors++; $display("FAIL abort_mid_done got %0d required 0", done_cnt); end
        clear_book();
        pulse_start("reload");
        stream(8, 1'b0, -1);
        repeat (4) @(negedge clk_250MHz);
        checks += 2;
        if (wen_cnt != 1)   begin errors++; $display("FAIL reload_wen_count got %0d required 1", wen_cnt); end
        if (sb.size() != 0) begin errors++; $display("FAIL reload_pending got %0d required 0", sb.size()); end
        @(posedge clk_250MHz); #1 abort = 1'b1;
        @(posedge clk_250MHz); #1 abort = 1'b0;
    endtask

    task automatic test_abort_on_eighth();
        clear_book();
        pulse_start("abort8");
        stream(7, 1'b0, -1);
        s_valid = 1'b1;
        s_data  = 32'd7;
        abort   = 1'b1;
        @(posedge clk_250MHz); #1;
        s_valid = 1'b0;
        abort   = 1'b0;
        checks++;
        if (in_ram_wen !== 8'h00) begin errors++; $display("FAIL abort8_wen got %h required 00", in_ram_wen); end
        repeat (4) @(negedge clk_250MHz);
        checks += 2;
        if (wen_cnt != 0)  begin errors++; $display("FAIL abort8_wen_count got %0d required 0", wen_cnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL abort8_busy got %b required 0", busy); end
    endtask

    task automatic test_reset_mid_write();
        clear_book();
        pulse_start("rstmid");
        stream(8, 1'b0, -1);
        checks++;
        if (in_ram_wen !== 8'h01) begin errors++; $display("FAIL rstmid_pre_wen got %h required 01", in_ram_wen); end
        rst = 1'b1;
        #1;
        checks += 3;
        if (in_ram_wen !== 8'h00) begin errors++; $display("FAIL rstmid_wen got %h required 00", in_ram_wen); end
        if (busy !== 1'b0)        begin errors++; $display("FAIL rstmid_busy got %b required 0", busy); end
        if (s_ready !== 1'b0)     begin errors++; $display("FAIL rstmid_s_ready got %b required 0", s_ready); end
        sb.delete();
        @(posedge clk_250MHz); #1 rst = 1'b0;
        @(negedge clk_250MHz);
        checks += 3;
        if (in_ram_wadrs !== 6'd0)  begin errors++; $display("FAIL rstmid_wadrs got %0d required 0", in_ram_wadrs); end
        if (in_ram_wdat !== 256'd0) begin errors++; $display("FAIL rstmid_wdat got %h required 0", in_ram_wdat); end
        if (busy !== 1'b0)          begin errors++; $display("FAIL rstmid_idle_busy got %b required 0", busy); end
    endtask

    initial begin
        clear_book();
        test_reset();
        test_full_load();
        test_random_valid();
        test_start_while_busy();
        test_abort_mid();
        test_abort_on_eighth();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
